// File: rtl/perceptron_predictor_pipe.sv
// Pipelined perceptron branch direction predictor with a speculative global
// history, an in-order pending queue and training at resolve time.
module perceptron_predictor_pipe #(
  parameter int HIST_LEN   = 8,
  parameter int ENTRIES    = 256,
  parameter int WEIGHT_W   = 8,
  parameter int THETA      = 14,
  parameter int PEND_DEPTH = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_req_valid,
  input  logic [31:0]                   i_req_pc,
  output logic                          o_req_ready,
  output logic                          o_pred_valid,
  output logic                          o_pred_taken,
  output logic [$clog2(PEND_DEPTH)-1:0] o_pred_tag,
  input  logic                          i_res_valid,
  input  logic                          i_res_taken,
  output logic                          o_res_ready,
  output logic                          o_flush,
  output logic                          o_init_busy
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = $clog2(PEND_DEPTH);
  localparam int CNT_W = TAG_W + 1;
  localparam int SUM_W = WEIGHT_W + $clog2(HIST_LEN + 1) + 1;
  localparam logic signed [WEIGHT_W-1:0] W_MAX = WEIGHT_W'((2 ** (WEIGHT_W - 1)) - 1);
  localparam logic signed [WEIGHT_W-1:0] W_MIN = -W_MAX;
  localparam logic signed [SUM_W-1:0] THETA_S = SUM_W'(THETA);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t state, stateNext;
  logic [IDX_W-1:0] initCnt;
  logic [HIST_LEN-1:0] ghr;

  // Index 0 of each row is the bias, index j+1 is the weight of history bit j.
  logic signed [WEIGHT_W-1:0] weights [ENTRIES][HIST_LEN+1];

  logic [IDX_W-1:0]    qIdx   [PEND_DEPTH];
  logic [HIST_LEN-1:0] qHist  [PEND_DEPTH];
  logic                qTaken [PEND_DEPTH];
  logic                qLow   [PEND_DEPTH];
  logic [TAG_W-1:0]    head, tail;
  logic [CNT_W-1:0]    count;

  logic [IDX_W-1:0]       reqIdx, trainIdx;
  logic signed [SUM_W-1:0] sum, absSum;
  logic predTakenNext, lowConf;
  logic running, full, empty;
  logic resFire, mispredict, train, reqFire;
  logic unusedPc;

  function automatic logic signed [WEIGHT_W-1:0] satStep(
    input logic signed [WEIGHT_W-1:0] w,
    input logic                       up
  );
    if (up) return (w == W_MAX) ? w : w + WEIGHT_W'(1);
    return (w == W_MIN) ? w : w - WEIGHT_W'(1);
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_INIT;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (state == ST_INIT && initCnt == IDX_W'(ENTRIES - 1)) stateNext = ST_RUN;
  end

  assign reqIdx   = i_req_pc[2 +: IDX_W];
  assign unusedPc = ^{i_req_pc[31:2+IDX_W], i_req_pc[1:0]};

  always_comb begin
    sum = SUM_W'(weights[reqIdx][0]);
    for (int j = 0; j < HIST_LEN; j++) begin
      if (ghr[j]) sum = sum + SUM_W'(weights[reqIdx][j+1]);
      else        sum = sum - SUM_W'(weights[reqIdx][j+1]);
    end
    predTakenNext = !sum[SUM_W-1];
    absSum        = sum[SUM_W-1] ? -sum : sum;
    lowConf       = (absSum <= THETA_S);
  end

  // A mispredicting resolve blocks new requests so the history restore wins.
  assign running    = (state == ST_RUN);
  assign full       = (count == CNT_W'(PEND_DEPTH));
  assign empty      = (count == '0);
  assign resFire    = i_res_valid && o_res_ready;
  assign mispredict = resFire && (i_res_taken != qTaken[head]);
  assign train      = resFire && (mispredict || qLow[head]);
  assign reqFire    = i_req_valid && o_req_ready;
  assign trainIdx   = qIdx[head];

  assign o_res_ready = running && !empty;
  assign o_req_ready = running && !full && !mispredict;
  assign o_init_busy = (state == ST_INIT);

  always_ff @(posedge i_clk) begin
    if (state == ST_INIT) begin
      for (int k = 0; k <= HIST_LEN; k++) weights[initCnt][k] <= '0;
    end else if (train && !i_rst) begin
      weights[trainIdx][0] <= satStep(weights[trainIdx][0], i_res_taken);
      for (int j = 0; j < HIST_LEN; j++)
        weights[trainIdx][j+1] <= satStep(weights[trainIdx][j+1], qHist[head][j] == i_res_taken);
    end
  end

  always_ff @(posedge i_clk) begin
    if (reqFire) begin
      qIdx[tail]   <= reqIdx;
      qHist[tail]  <= ghr;
      qTaken[tail] <= predTakenNext;
      qLow[tail]   <= lowConf;
    end
  end

  // On a mispredict the queue restarts at slot 0 with the repaired history.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      initCnt      <= '0;
      ghr          <= '0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      o_pred_valid <= 1'b0;
      o_pred_taken <= 1'b0;
      o_pred_tag   <= '0;
      o_flush      <= 1'b0;
    end else begin
      o_pred_valid <= reqFire;
      o_flush      <= mispredict;
      if (state == ST_INIT) initCnt <= initCnt + IDX_W'(1);
      if (reqFire) begin
        o_pred_taken <= predTakenNext;
        o_pred_tag   <= tail;
      end
      if (mispredict) begin
        ghr   <= {qHist[head][HIST_LEN-2:0], i_res_taken};
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (reqFire) begin
          ghr  <= {ghr[HIST_LEN-2:0], predTakenNext};
          tail <= tail + TAG_W'(1);
        end
        if (resFire) head <= head + TAG_W'(1);
        count <= count + CNT_W'(reqFire) - CNT_W'(resFire);
      end
    end
  end

endmodule

// File: tb/tb_perceptron_predictor_pipe.sv
// Randomized bench for perceptron_predictor_pipe against an integer-arithmetic
// model of the predictor, plus a high-THETA instance for weight saturation.
module tb_perceptron_predictor_pipe;

  localparam int ENTRIES = 256;
  localparam int PEND    = 8;
  localparam int HIST    = 8;
  localparam int WMAX    = 127;
  localparam int THETA   = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, reqValid, resValid, resTaken;
  logic [31:0] reqPc;
  logic        reqReady, predValid, predTaken, resReady, flush, initBusy;
  logic [2:0]  predTag;
  logic        satReqReady, satPredValid, satPredTaken, satResReady, satFlush, satInitBusy;
  logic [2:0]  satPredTag;

  perceptron_predictor_pipe dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(reqValid), .i_req_pc(reqPc),
    .o_req_ready(reqReady), .o_pred_valid(predValid), .o_pred_taken(predTaken),
    .o_pred_tag(predTag), .i_res_valid(resValid), .i_res_taken(resTaken),
    .o_res_ready(resReady), .o_flush(flush), .o_init_busy(initBusy)
  );

  // Every resolve trains here, so the bias walks straight into saturation.
  perceptron_predictor_pipe #(.ENTRIES(4), .THETA(2000)) dutSat (
    .i_clk(clk), .i_rst(rst), .i_req_valid(reqValid), .i_req_pc(reqPc),
    .o_req_ready(satReqReady), .o_pred_valid(satPredValid), .o_pred_taken(satPredTaken),
    .o_pred_tag(satPredTag), .i_res_valid(resValid), .i_res_taken(resTaken),
    .o_res_ready(satResReady), .o_flush(satFlush), .o_init_busy(satInitBusy)
  );

  typedef struct {int idx; int hist; bit taken; bit low;} pend_t;

  int    testsRun = 0, testsFailed = 0;
  int    mw [ENTRIES][HIST+1];
  int    mGhr, initLeft, tailTag, expTag;
  bit    expPV, expPT, expFlush, postReset;
  pend_t pq[$];

  task automatic checkOutput(input string tag, input int observed, input int expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int r = 0; r < ENTRIES; r++)
      for (int k = 0; k <= HIST; k++) mw[r][k] = 0;
    mGhr = 0; pq.delete(); initLeft = ENTRIES; tailTag = 0;
    expPV = 0; expPT = 0; expTag = 0; expFlush = 0; postReset = 1;
  endtask

  function automatic int clampW(input int v);
    if (v > WMAX)  return WMAX;
    if (v < -WMAX) return -WMAX;
    return v;
  endfunction

  // One clock of stimulus: check what the DUT shows now, then advance the model.
  task automatic applyStimulus(input bit rv, input int pc, input bit sv, input bit st, input bit rs);
    bit mRes, mResFire, mMis, mReq, mReqFire, pTaken, pLow;
    int idx, sum;
    pend_t e;
    @(negedge clk);
    rst = rs; reqValid = rv; reqPc = pc; resValid = sv; resTaken = st;
    #1;
    mRes     = (initLeft == 0) && (pq.size() > 0);
    mResFire = sv && mRes;
    mMis     = mResFire && (st != pq[0].taken);
    mReq     = (initLeft == 0) && (pq.size() < PEND) && !mMis;
    mReqFire = rv && mReq;
    checkOutput("initBusy", initBusy, int'(initLeft > 0));
    checkOutput("reqReady", reqReady, int'(mReq));
    checkOutput("resReady", resReady, int'(mRes));
    checkOutput("predValid", predValid, int'(expPV));
    checkOutput("flush", flush, int'(expFlush));
    if (expPV || postReset) begin
      checkOutput("predTaken", predTaken, int'(expPT));
      checkOutput("predTag", predTag, expTag);
    end
    postReset = 0;
    if (rs) begin
      modelReset();
    end else begin
      if (initLeft > 0) initLeft--;
      expPV = mReqFire; expFlush = mMis;
      idx = (pc >> 2) & (ENTRIES - 1);
      sum = mw[idx][0];
      for (int j = 0; j < HIST; j++)
        sum += ((mGhr >> j) & 1) ? mw[idx][j+1] : -mw[idx][j+1];
      pTaken = (sum >= 0);
      pLow   = ((sum < 0) ? -sum : sum) <= THETA;
      if (mReqFire) begin expPT = pTaken; expTag = tailTag; end
      if (mResFire) begin
        e = pq.pop_front();
        if (mMis || e.low) begin
          mw[e.idx][0] = clampW(mw[e.idx][0] + (st ? 1 : -1));
          for (int j = 0; j < HIST; j++)
            mw[e.idx][j+1] = clampW(mw[e.idx][j+1] + ((((e.hist >> j) & 1) == int'(st)) ? 1 : -1));
        end
        if (mMis) begin
          mGhr = ((e.hist << 1) | int'(st)) & 255;
          pq.delete();
          tailTag = 0;
        end
      end
      if (mReqFire) begin
        e.idx = idx; e.hist = mGhr; e.taken = pTaken; e.low = pLow;
        pq.push_back(e);
        mGhr = ((mGhr << 1) | int'(pTaken)) & 255;
        tailTag = (tailTag + 1) % PEND;
      end
    end
  endtask

  function automatic bit headTaken();
    return (pq.size() > 0) ? pq[0].taken : 1'b0;
  endfunction

  initial begin
    rst = 1'b1; reqValid = 1'b0; reqPc = '0; resValid = 1'b0; resTaken = 1'b0;
    repeat (2) @(posedge clk);
    modelReset();

    // Requests held high through the whole initialisation window.
    for (int i = 0; i < ENTRIES + 1; i++) applyStimulus(1, 32'h100, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);

    // Correct resolve, then a second prediction on the same row.
    applyStimulus(0, 0, 1, 1, 0);
    applyStimulus(1, 32'h100, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 0);
    applyStimulus(0, 0, 0, 0, 0);
    for (int k = 0; k <= HIST; k++)
      checkOutput($sformatf("row40w%0d", k), int'(dut.weights[64][k]), mw[64][k]);

    // Mispredict with a competing request in the resolve cycle.
    applyStimulus(1, 32'h100, 0, 0, 0);
    applyStimulus(1, 32'h104, 1, ~headTaken(), 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);

    // Fill the queue, push once more, then push and pop together.
    for (int i = 0; i < PEND + 1; i++) applyStimulus(1, 32'h100 + 4 * i, 0, 0, 0);
    applyStimulus(1, 32'h200, 1, headTaken(), 0);
    applyStimulus(0, 0, 0, 0, 0);
    while (pq.size() > 0) applyStimulus(0, 0, 1, headTaken(), 0);

    // Reset with five predictions in flight.
    for (int i = 0; i < 5; i++) applyStimulus(1, 32'h40 * i, 0, 0, 0);
    applyStimulus(1, 32'h100, 1, ~headTaken(), 1);
    for (int i = 0; i < ENTRIES + 2; i++)
      applyStimulus($urandom_range(0, 1), $urandom, $urandom_range(0, 1), $urandom_range(0, 1), 0);

    // Random traffic over a few rows; resolves mostly agree with the prediction.
    for (int i = 0; i < 3000; i++) begin
      bit rv, sv, st;
      int pc;
      rv = ($urandom_range(0, 9) < 8);
      sv = ($urandom_range(0, 9) < 3);
      st = ($urandom_range(0, 4) == 0) ? ~headTaken() : headTaken();
      pc = (($urandom_range(0, 3) + 64 * $urandom_range(0, 1)) << 2) | $urandom_range(0, 3);
      applyStimulus(rv, pc, sv, st, 0);
    end

    // Saturation walk on row 0 of the always-training instance.
    applyStimulus(0, 0, 0, 0, 1);
    for (int i = 0; i < ENTRIES; i++) applyStimulus(0, 0, 0, 0, 0);
    for (int i = 0; i < 200; i++) begin
      applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(0, 0, 1, 1, 0);
    end
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("satBiasHigh", int'(dutSat.weights[0][0]), 127);
    for (int i = 0; i < 200; i++) begin
      applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(0, 0, 1, 0, 0);
    end
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("satBiasLow", int'(dutSat.weights[0][0]), -73);
    checkOutput("row0Bias", int'(dut.weights[0][0]), mw[0][0]);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
